// File: rtl/egress_cell_reasm_pkg.sv
// egress_cell_reasm_pkg: shared cell/beat constants, stored-beat layout and FSM states
package egress_cell_reasm_pkg;
    localparam int CELL_BEATS = 4;
    localparam int BEAT_BYTES = 16;
    localparam int LEN_MSB = 11;
    localparam int LEN_LSB = 0;
    localparam int BEAT_W = 134;

    typedef struct packed {
        logic         eop;
        logic         sop;
        logic [3:0]   bytes;
        logic [127:0] data;
    } beat_t;

    typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, DISCARD} state_t;
endpackage

// File: rtl/egress_beat_ram.sv
// egress_beat_ram: simple dual-port frame buffer with registered read
module egress_beat_ram
    import egress_cell_reasm_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BEAT_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [BEAT_W-1:0] rdata
);
    logic [BEAT_W-1:0] mem [DEPTH];

    // write port and registered read port; rdata holds while re is low
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/egress_cell_reasm.sv
// egress_cell_reasm: strips headers and pads from 4-beat cells, stores whole frames, replays committed frames
module egress_cell_reasm
    import egress_cell_reasm_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int BP_FREE = 12,
    parameter int MAX_LEN = 2047
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cell_wr,
    input  logic [127:0] cell_din,
    input  logic         cell_first,
    input  logic         cell_last,
    output logic         cell_bp,
    output logic [127:0] o_data,
    output logic         o_valid,
    output logic         o_sop,
    output logic         o_eop,
    output logic [3:0]   o_bytes,
    input  logic         o_ready,
    output logic [15:0]  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    state_t        state, state_n;
    logic [1:0]    beat_cnt;
    logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, wr_n, cmt_n, used, free;
    logic [7:0]    rem, rem_n, need;
    logic [3:0]    len_lo, len_lo_n;
    logic [11:0]   hdr_len;
    logic          sop_pend, sop_pend_n, last_q, ovf_q, ovf_n;
    logic          hdr, hdr_ok, drop_inc, we, re, out_v;
    beat_t         wbeat, rbeat;

    assign hdr_len = cell_din[LEN_MSB:LEN_LSB];
    assign need = 8'((13'(hdr_len) + 13'd15) >> 4);
    assign hdr_ok = hdr_len != 12'd0 && hdr_len <= 12'(MAX_LEN);
    assign used = wr_ptr - rd_ptr;
    assign free = PW'(DEPTH) - used;
    assign hdr = beat_cnt == 2'd0 && (state == IDLE || (cell_first && state != DISCARD));
    assign re = rd_ptr != cmt_ptr && (!out_v || o_ready);

    // cell FSM: header parse, payload write, overflow, and end-of-cell commit/rollback
    always_comb begin
        state_n = state;
        wr_n = wr_ptr;
        cmt_n = cmt_ptr;
        rem_n = rem;
        len_lo_n = len_lo;
        sop_pend_n = sop_pend;
        ovf_n = ovf_q;
        drop_inc = 1'b0;
        we = 1'b0;
        wbeat = '{eop: rem == 8'd1, sop: sop_pend, bytes: rem == 8'd1 ? len_lo : 4'd0, data: cell_din};
        if (cell_wr) begin
            if (hdr) begin
                drop_inc = state != IDLE;
                wr_n = cmt_ptr;
                state_n = cell_first && hdr_ok ? PAYLOAD : DISCARD;
                rem_n = need;
                len_lo_n = hdr_len[3:0];
                sop_pend_n = 1'b1;
            end else if (state == PAYLOAD) begin
                if (used == PW'(DEPTH)) begin
                    wr_n = cmt_ptr;
                    drop_inc = 1'b1;
                    ovf_n = 1'b1;
                    state_n = DISCARD;
                end else begin
                    we = 1'b1;
                    wr_n = wr_ptr + PW'(1);
                    rem_n = rem - 8'd1;
                    sop_pend_n = 1'b0;
                    state_n = rem == 8'd1 ? PAD : PAYLOAD;
                end
            end
            if (beat_cnt == 2'd3 && last_q) begin
                if (state_n == PAD) cmt_n = wr_n;
                else if (state_n == PAYLOAD) begin
                    wr_n = cmt_ptr;
                    drop_inc = 1'b1;
                end else if (state_n == DISCARD && !ovf_n) drop_inc = 1'b1;
                state_n = IDLE;
                ovf_n = 1'b0;
            end
        end
    end

    // write-side state, pointers and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat_cnt <= 2'd0;
            wr_ptr <= '0;
            cmt_ptr <= '0;
            rem <= 8'd0;
            len_lo <= 4'd0;
            sop_pend <= 1'b0;
            last_q <= 1'b0;
            ovf_q <= 1'b0;
            drop_cnt <= 16'd0;
        end else begin
            state <= state_n;
            wr_ptr <= wr_n;
            cmt_ptr <= cmt_n;
            rem <= rem_n;
            len_lo <= len_lo_n;
            sop_pend <= sop_pend_n;
            ovf_q <= ovf_n;
            if (cell_wr) beat_cnt <= beat_cnt + 2'd1;
            if (cell_wr && beat_cnt == 2'd0) last_q <= cell_last;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // read side: RAM output register is the FWFT output, refilled whenever it empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            out_v <= 1'b0;
        end else begin
            if (re) rd_ptr <= rd_ptr + PW'(1);
            out_v <= re || (out_v && !o_ready);
        end
    end

    // back-pressure from speculative fill level, so uncommitted beats count as used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cell_bp <= 1'b0;
        else cell_bp <= free < PW'(BP_FREE);
    end

    egress_beat_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(wbeat),
        .re   (re),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rbeat)
    );

    assign o_valid = out_v;
    assign o_data = out_v ? rbeat.data : 128'd0;
    assign o_sop = out_v && rbeat.sop;
    assign o_eop = out_v && rbeat.eop;
    assign o_bytes = out_v ? rbeat.bytes : 4'd0;
endmodule

// File: tb/tb_egress_cell_reasm.sv
// tb_egress_cell_reasm: directed frames through a 16-beat reassembler with hand-computed expectations
module tb_egress_cell_reasm;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cell_wr = 1'b0;
    logic [127:0] cell_din = '0;
    logic         cell_first = 1'b0;
    logic         cell_last = 1'b0;
    logic         cell_bp;
    logic [127:0] o_data;
    logic         o_valid, o_sop, o_eop;
    logic [3:0]   o_bytes;
    logic         o_ready = 1'b1;
    logic [15:0]  drop_cnt;
    int           total = 0;
    int           bad = 0;
    logic [127:0] q_data [$];
    logic [5:0]   q_flag [$];

    egress_cell_reasm #(.DEPTH(16), .BP_FREE(12), .MAX_LEN(2047)) dut (
        .clk       (clk),
        .rst       (rst),
        .cell_wr   (cell_wr),
        .cell_din  (cell_din),
        .cell_first(cell_first),
        .cell_last (cell_last),
        .cell_bp   (cell_bp),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_sop     (o_sop),
        .o_eop     (o_eop),
        .o_bytes   (o_bytes),
        .o_ready   (o_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // record every beat that will transfer on the coming edge
    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            q_data.push_back(o_data);
            q_flag.push_back({o_sop, o_eop, o_bytes});
        end
    end

    function automatic logic [127:0] pd(input int id, input int k);
        return {64'hA5A5_5A5A_C3C3_3C3C, 32'(id), 32'(k)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input int id, input int cells, input bit last_on);
        int need, n, i;
        need = (len + 15) / 16;
        n = cells == 0 ? (need + 4) / 4 : cells;
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 4; k++) begin
                i = c * 4 + k;
                cell_wr = 1'b1;
                cell_din = i == 0 ? {116'hBEEF_0000_DEAD, 12'(len)} : (i <= need ? pd(id, i - 1) : {4{32'hEEEE_0BAD}});
                cell_first = c == 0;
                cell_last = last_on && c == n - 1;
                @(posedge clk);
                #1;
            end
        end
        cell_wr = 1'b0;
        cell_first = 1'b0;
        cell_last = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int id, input int n, input int nb);
        logic [127:0] d;
        logic [5:0] f;
        int t;
        t = 0;
        while (q_data.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (q_data.size() < n) begin
            chk({tag, "_timeout"}, 128'(q_data.size()), 128'(n));
            return;
        end
        for (int k = 0; k < n; k++) begin
            d = q_data.pop_front();
            f = q_flag.pop_front();
            chk({tag, "_data"}, d, pd(id, k));
            chk({tag, "_sop"}, 128'(f[5]), 128'(k == 0));
            chk({tag, "_eop"}, 128'(f[4]), 128'(k == n - 1));
            chk({tag, "_bytes"}, 128'(f[3:0]), 128'(k == n - 1 ? nb : 0));
        end
    endtask

    initial begin
        idle(3);
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_bp", 128'(cell_bp), 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        rst = 1'b0;
        idle(2);

        send_frame(100, 1, 0, 1'b1);
        check_frame("len100", 1, 7, 4);
        chk("len100_drop", 128'(drop_cnt), 128'(0));

        send_frame(48, 2, 0, 1'b1);
        check_frame("len48", 2, 3, 0);
        idle(10);
        chk("len48_nohdr", 128'(q_data.size()), 128'(0));

        send_frame(200, 3, 2, 1'b1);
        idle(40);
        chk("short_empty", 128'(q_data.size()), 128'(0));
        chk("short_drop", 128'(drop_cnt), 128'(1));
        send_frame(64, 4, 0, 1'b1);
        check_frame("len64", 4, 4, 0);

        send_frame(200, 11, 2, 1'b0);
        send_frame(33, 12, 0, 1'b1);
        check_frame("resync", 12, 3, 1);
        chk("resync_drop", 128'(drop_cnt), 128'(2));
        idle(20);
        chk("resync_empty", 128'(q_data.size()), 128'(0));

        o_ready = 1'b0;
        send_frame(80, 5, 0, 1'b1);
        idle(5);
        chk("bp_at12", 128'(cell_bp), 128'(0));
        chk("stall_valid", 128'(o_valid), 128'(1));
        chk("stall_data", o_data, pd(5, 0));
        send_frame(32, 6, 0, 1'b1);
        idle(5);
        chk("bp_at10", 128'(cell_bp), 128'(1));
        send_frame(200, 7, 0, 1'b1);
        idle(5);
        chk("ovf_drop", 128'(drop_cnt), 128'(3));
        chk("ovf_bp", 128'(cell_bp), 128'(1));
        chk("ovf_held", o_data, pd(5, 0));
        chk("ovf_noxfer", 128'(q_data.size()), 128'(0));
        o_ready = 1'b1;
        check_frame("keep_a", 5, 5, 0);
        check_frame("keep_b", 6, 2, 0);
        idle(20);
        chk("ovf_tail", 128'(q_data.size()), 128'(0));
        chk("bp_drained", 128'(cell_bp), 128'(0));

        o_ready = 1'b0;
        send_frame(160, 8, 0, 1'b1);
        idle(5);
        chk("pre_rst_bp", 128'(cell_bp), 128'(1));
        chk("pre_rst_valid", 128'(o_valid), 128'(1));
        send_frame(200, 10, 1, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(o_valid), 128'(0));
        chk("mid_rst_bp", 128'(cell_bp), 128'(0));
        chk("mid_rst_drop", 128'(drop_cnt), 128'(0));
        idle(2);
        rst = 1'b0;
        o_ready = 1'b1;
        idle(10);
        chk("post_rst_empty", 128'(q_data.size()), 128'(0));
        chk("post_rst_valid", 128'(o_valid), 128'(0));
        send_frame(48, 9, 0, 1'b1);
        check_frame("post_rst", 9, 3, 0);
        chk("post_rst_drop", 128'(drop_cnt), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
